// File: rtl/floating_point_adder.sv
// rtl/floating_point_adder.sv - binary32 truncating adder with registered result and overflow flag
// Combinational add/subtract core; outputs update one cycle after operands are sampled with en high.
module floating_point_adder (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inputA,
  input  logic [31:0] inputB,
  input  logic        en,
  output logic [31:0] Sum,
  output logic        OverflowFlag
);

  function automatic logic [4:0] leadingZeros(input logic [23:0] value);
    logic found;
    leadingZeros = 5'd0;
    found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!found && value[i]) begin
        leadingZeros = 5'(23 - i);
        found = 1'b1;
      end
    end
  endfunction

  logic        signA, signB;
  logic [7:0]  expA, expB;
  logic [22:0] fracA, fracB;
  logic        specialA, specialB, nanA, nanB;

  assign signA    = inputA[31];
  assign signB    = inputB[31];
  assign expA     = inputA[30:23];
  assign expB     = inputB[30:23];
  assign fracA    = inputA[22:0];
  assign fracB    = inputB[22:0];
  assign specialA = (expA == 8'hFF);
  assign specialB = (expB == 8'hFF);
  assign nanA     = specialA && (fracA != 23'd0);
  assign nanB     = specialB && (fracB != 23'd0);

  // Exponent and fraction are contiguous, so one unsigned compare orders magnitudes.
  logic        aBigger;
  logic        bigSign;
  logic [7:0]  bigExp, smallExp, expDiff;
  logic [23:0] bigSig, smallSig, alignedSig;

  assign aBigger    = (inputA[30:0] >= inputB[30:0]);
  assign bigSign    = aBigger ? signA : signB;
  assign bigExp     = aBigger ? expA : expB;
  assign smallExp   = aBigger ? expB : expA;
  assign bigSig     = aBigger ? {1'b1, fracA} : {1'b1, fracB};
  assign smallSig   = aBigger ? {1'b1, fracB} : {1'b1, fracA};
  assign expDiff    = bigExp - smallExp;
  assign alignedSig = (expDiff >= 8'd24) ? 24'd0 : (smallSig >> expDiff);

  logic [24:0] addSum;
  logic [23:0] addSig;
  logic [8:0]  addExp;

  assign addSum = {1'b0, bigSig} + {1'b0, alignedSig};
  assign addSig = addSum[24] ? addSum[24:1] : addSum[23:0];
  assign addExp = {1'b0, bigExp} + {8'd0, addSum[24]};

  logic [23:0]        subDiff, normSig;
  logic [4:0]         lzCount;
  logic signed [9:0]  subExp;

  assign subDiff = bigSig - alignedSig;
  assign lzCount = leadingZeros(subDiff);
  assign normSig = subDiff << lzCount;
  assign subExp  = $signed({2'b00, bigExp}) - $signed({5'd0, lzCount});

  logic [31:0] nextSum;
  logic        nextFlag;

  always_comb begin
    nextSum  = 32'h0000_0000;
    nextFlag = 1'b0;
    if (specialA || specialB) begin
      nextFlag = 1'b1;
      if (nanA || nanB || (specialA && specialB && (signA != signB)))
        nextSum = 32'h7FC0_0000;
      else if (specialA)
        nextSum = {signA, 8'hFF, 23'd0};
      else
        nextSum = {signB, 8'hFF, 23'd0};
    end else if (expA == 8'd0) begin
      nextSum = (expB == 8'd0) ? 32'h0000_0000 : inputB;
    end else if (expB == 8'd0) begin
      nextSum = inputA;
    end else if (signA == signB) begin
      if (addExp >= 9'd255) begin
        nextFlag = 1'b1;
        nextSum  = {signA, 8'hFF, 23'd0};
      end else begin
        nextSum = {signA, addExp[7:0], addSig[22:0]};
      end
    end else if ((subDiff != 24'd0) && (subExp > 10'sd0)) begin
      // Cancellation and underflow both fall through to the +0 default.
      nextSum = {bigSign, subExp[7:0], normSig[22:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Sum          <= 32'h0000_0000;
      OverflowFlag <= 1'b0;
    end else if (en) begin
      Sum          <= nextSum;
      OverflowFlag <= nextFlag;
    end
  end

endmodule

// File: tb/tb_floating_point_adder.sv
// tb/tb_floating_point_adder.sv - randomized and directed checks of floating_point_adder
// Reference arithmetic is done on plain integers with divide/multiply loops.
module tb_floating_point_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inputA, inputB;
  logic        en;
  logic [31:0] Sum;
  logic        OverflowFlag;

  int          nCompared = 0;
  int          nMismatched = 0;
  logic        checking = 1'b0;
  logic [32:0] expVec = 33'd0;

  floating_point_adder dut (
    .clk(clk),
    .rst(rst),
    .inputA(inputA),
    .inputB(inputB),
    .en(en),
    .Sum(Sum),
    .OverflowFlag(OverflowFlag)
  );

  always #5 clk = ~clk;

  // Returns {flag, sum}.
  function automatic logic [32:0] refModel(input logic [31:0] a, input logic [31:0] b);
    int     ea, eb, eL, eS, e, diff;
    longint sigL, sigS, r;
    bit     sL, sa, sb, nanA, nanB;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    sa = a[31];
    sb = b[31];
    if (ea == 255 || eb == 255) begin
      nanA = (ea == 255) && (a[22:0] != 0);
      nanB = (eb == 255) && (b[22:0] != 0);
      if (nanA || nanB || (ea == 255 && eb == 255 && sa != sb)) return {1'b1, 32'h7FC0_0000};
      if (ea == 255) return {1'b1, sa, 8'hFF, 23'd0};
      return {1'b1, sb, 8'hFF, 23'd0};
    end
    if (ea == 0 && eb == 0) return 33'd0;
    if (ea == 0) return {1'b0, b};
    if (eb == 0) return {1'b0, a};
    if (a[30:0] >= b[30:0]) begin
      eL = ea; eS = eb; sL = sa;
      sigL = 64'h80_0000 + longint'(a[22:0]);
      sigS = 64'h80_0000 + longint'(b[22:0]);
    end else begin
      eL = eb; eS = ea; sL = sb;
      sigL = 64'h80_0000 + longint'(b[22:0]);
      sigS = 64'h80_0000 + longint'(a[22:0]);
    end
    diff = eL - eS;
    if (diff >= 24) sigS = 0;
    else sigS = sigS / (64'd1 << diff);
    e = eL;
    if (sa == sb) begin
      r = sigL + sigS;
      while (r >= 64'h100_0000) begin
        r = r / 2;
        e = e + 1;
      end
      if (e >= 255) return {1'b1, sa, 8'hFF, 23'd0};
      return {1'b0, sa, 8'(e), 23'(r)};
    end
    r = sigL - sigS;
    if (r == 0) return 33'd0;
    while (r < 64'h80_0000) begin
      r = r * 2;
      e = e - 1;
    end
    if (e <= 0) return 33'd0;
    return {1'b0, sL, 8'(e), 23'(r)};
  endfunction

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] want);
    nCompared++;
    if (act !== want) begin
      nMismatched++;
      $display("FAIL %s: got flag=%b sum=%h, expected flag=%b sum=%h",
               name, act[32], act[31:0], want[32], want[31:0]);
    end
  endtask

  always @(posedge clk) begin
    if (rst) expVec <= 33'd0;
    else if (en) expVec <= refModel(inputA, inputB);
  end

  always @(negedge clk) begin
    if (checking) check("cycle", {OverflowFlag, Sum}, expVec);
  end

  task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [32:0] want);
    check({name, " model"}, refModel(a, b), want);
    @(negedge clk);
    #1;
    inputA = a;
    inputB = b;
    en = 1'b1;
    @(negedge clk);
    check({name, " dut"}, {OverflowFlag, Sum}, want);
  endtask

  function automatic logic [31:0] randOp(input logic [7:0] nearExp, input bit useNear);
    logic [7:0]  e;
    logic [22:0] f;
    int          kind;
    kind = $urandom_range(0, 15);
    f = 23'($urandom);
    if (kind == 0) e = 8'd0;
    else if (kind == 1) e = 8'hFF;
    else if (kind == 2) e = 8'hFE;
    else if (kind == 3) e = 8'($urandom_range(1, 4));
    else if (useNear && kind <= 10) e = nearExp + 8'($urandom_range(0, 30)) - 8'd15;
    else e = 8'($urandom_range(1, 254));
    if (e == 8'hFF && $urandom_range(0, 1) == 1) f = 23'd0;
    return {1'($urandom), e, f};
  endfunction

  initial begin
    logic [31:0] a, b;
    rst = 1'b1;
    en = 1'b1;
    inputA = 32'h4048_F5C3;
    inputB = 32'hC2C8_0000;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("reset", {OverflowFlag, Sum}, 33'd0);
    checking = 1'b1;
    #1;
    rst = 1'b0;

    directed("mixed align", 32'hC102_0000, 32'h3F81_47AE, {1'b0, 32'hC0E3_AE16});
    directed("mixed 22-23", 32'h41B0_0000, 32'hC1B8_0000, {1'b0, 32'hBF80_0000});
    directed("carry pos",   32'h4060_0000, 32'h3F99_999A, {1'b0, 32'h4096_6666});
    directed("carry neg",   32'hC060_0000, 32'hBF99_999A, {1'b0, 32'hC096_6666});
    directed("sub norm 1",  32'h41F8_0000, 32'hC0E0_0000, {1'b0, 32'h41C0_0000});
    directed("sub norm 2",  32'h4276_CCCD, 32'hC089_999A, {1'b0, 32'h4265_999A});
    directed("ovf pos",     32'h7F7F_FFFF, 32'h7F7F_FFFF, {1'b1, 32'h7F80_0000});
    directed("ovf neg",     32'hFF7F_FFFF, 32'hFF7F_FFFF, {1'b1, 32'hFF80_0000});
    directed("ovf mixed",   32'hFF7F_F023, 32'hFD10_71DB, {1'b1, 32'hFF80_0000});
    directed("inf minus",   32'h7F80_0000, 32'hFF80_0000, {1'b1, 32'h7FC0_0000});
    directed("nan in",      32'h3F80_0000, 32'h7F80_0001, {1'b1, 32'h7FC0_0000});
    directed("inf plus x",  32'h4000_0000, 32'hFF80_0000, {1'b1, 32'hFF80_0000});
    directed("zero op",     32'h0012_3456, 32'hC123_4567, {1'b0, 32'hC123_4567});
    directed("two zeros",   32'h8000_0000, 32'h8000_0000, {1'b0, 32'h0000_0000});
    directed("underflow",   32'h0080_0001, 32'h8080_0000, {1'b0, 32'h0000_0000});
    directed("cancel",      32'h3F80_0000, 32'hBF80_0000, {1'b0, 32'h0000_0000});

    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      en = 1'b0;
      inputA = 32'h4000_0000 + 32'($urandom_range(0, 1000));
      inputB = 32'h4100_0000;
      @(negedge clk);
      check("enable hold", {OverflowFlag, Sum}, 33'd0);
    end

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      rst = ($urandom_range(0, 99) == 0);
      en = ($urandom_range(0, 3) != 0);
      a = randOp(8'd127, 1'b0);
      if ($urandom_range(0, 9) == 0) b = a ^ 32'h8000_0000;
      else b = randOp(a[30:23], 1'b1);
      if ($urandom_range(0, 1) == 1) begin
        inputA = a;
        inputB = b;
      end else begin
        inputA = b;
        inputB = a;
      end
    end
    @(negedge clk);
    #1;
    rst = 1'b0;
    en = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/floating_point_adder.md
Name: floating_point_adder

Overview:
- Single-precision (IEEE-754 binary32 format) adder/subtractor for the datapath, combinational core with registered outputs.
- Adds two 32-bit floats with truncation (round-toward-zero on every discarded bit).
- Flags exponent overflow.
- Sits between operand registers and the result bus. Result and flag update one clock after operands are sampled with en high.

Parameters:
- none (fixed binary32: 1 sign, 8 exponent bits with bias 127, 23 fraction bits)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- inputA  input  32  operand A (binary32)
- inputB  input  32  operand B (binary32)
- en  input  1  operation enable; sample operands and update outputs when high
- Sum  output  32  registered result (binary32)
- OverflowFlag  output  1  registered overflow indicator for the result in Sum

Behaviour:
- Reset: on a rising clk edge with rst=1, Sum=32'h0000_0000 and OverflowFlag=0. rst has priority over en.
- Latency: 1 cycle. On a clk edge with rst=0 and en=1, Sum and OverflowFlag take f(inputA, inputB). With en=0, both outputs hold.
- Unpack: a field with exponent 0 is zero (denormals flushed, fraction ignored). Otherwise significand = {1, fraction}, 24 bits.
- Align: the operand with the smaller magnitude (exponent first, then significand) is shifted right by the exponent difference. Shifted-out bits are discarded; there are no guard, round or sticky bits. A difference of 24 or more gives a 0 significand.
- Same signs: add the 24-bit significands into a 25-bit sum. On carry-out, shift right 1 (drop LSB) and increment the exponent. Result sign = common sign.
- Different signs: larger minus smaller. Result sign = sign of the larger-magnitude operand.
- Normalize: left-shift until bit 23 = 1, decrementing the exponent per shift (leading-zero count, 0..23).
  - If the exponent would reach 0 or below, the result is +0.
- Zero result: exact cancellation gives 32'h0000_0000 (positive zero), OverflowFlag=0.
- Overflow: if the final exponent is 255 or more, OverflowFlag=1 and Sum = signed infinity ({sign, 8'hFF, 23'h0}).
- Special inputs:
  - Either operand with exponent 255 gives OverflowFlag=1.
  - If either operand is NaN, or the operands are infinities of opposite sign, Sum = 32'h7FC0_0000.
  - Otherwise Sum = the infinity with that operand's sign.
- Zero operand: the result equals the other operand exactly (same bits), flag 0. Two zeros give +0.
- Rounding: truncation only; no rounding increment anywhere.

Test Plan:
- Reset: assert rst for 1 edge with arbitrary operands -> Sum=0x00000000, OverflowFlag=0.
- Mixed signs with alignment loss:
  - A=0xC1020000 (-8.125), B=0x3F8147AE (1.01), en=1 -> one edge later Sum=0xC0E3AE16, flag 0 (truncated alignment).
  - A=0x41B00000 (22), B=0xC1B80000 (-23) -> Sum=0xBF800000 (-1), flag 0.
- Same signs with carry:
  - A=0x40600000 (3.5), B=0x3F99999A (1.2) -> Sum=0x40966666, flag 0.
  - Sign-flipped operands -> Sum=0xC0966666.
- Subtract with normalization:
  - A=0x41F80000 (31), B=0xC0E00000 (-7) -> Sum=0x41C00000 (24).
  - A=0x4276CCCD (61.7), B=0xC089999A (-4.3) -> Sum=0x4265999A.
- Overflow:
  - A=B=0x7F7FFFFF -> OverflowFlag=1, Sum=0x7F800000.
  - A=B=0xFF7FFFFF -> flag 1, Sum=0xFF800000.
  - A=0xFF7FF023, B=0xFD1071DB -> flag 1.
- Cancellation and enable hold:
  - A=0x3F800000, B=0xBF800000 -> Sum=0x00000000, flag 0.
  - Then drop en and change operands -> outputs unchanged across several edges.
